// File: rtl/cpumc_arb_if.sv
// Bus bundle between the masters, the cpumc_arb arbiter and the single cpumc port.
// The slave modport is the arbiter's view; the master modport is the environment's view.
interface cpumc_arb_if #(
  parameter int unsigned NUM_M  = 3,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_M-1:0]        m_req;
  logic [NUM_M-1:0]        m_lock;
  logic [NUM_M-1:0]        m_r_nw;
  logic [NUM_M*ADDR_W-1:0] m_a;
  logic [NUM_M*DATA_W-1:0] m_wdata;
  logic [NUM_M-1:0]        m_gnt;
  logic [NUM_M-1:0]        m_rvalid;
  logic [DATA_W-1:0]       m_rdata;
  logic                    ovr;
  logic                    busy;
  logic [ADDR_W-1:0]       mc_a;
  logic                    mc_wr;
  logic [DATA_W-1:0]       mc_din;
  logic [DATA_W-1:0]       mc_dout;

  modport slave (
    input  m_req, m_lock, m_r_nw, m_a, m_wdata, ovr, mc_dout,
    output m_gnt, m_rvalid, m_rdata, busy, mc_a, mc_wr, mc_din
  );

  modport master (
    output m_req, m_lock, m_r_nw, m_a, m_wdata, ovr, mc_dout,
    input  m_gnt, m_rvalid, m_rdata, busy, mc_a, mc_wr, mc_din
  );
endinterface

// File: rtl/cpumc_arb.sv
// N-master round-robin arbiter in front of cpumc: registered issue, bus locking,
// debugger override and one-cycle read return.
module cpumc_arb #(
  parameter int unsigned NUM_M   = 3,
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned OVR_IDX = 1
) (
  input  logic           clk,
  input  logic           rst,
  cpumc_arb_if.slave     bus
);

  localparam int unsigned IDX_W = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  typedef enum logic [0:0] {ST_OPEN, ST_LOCKED} lock_st_e;

  lock_st_e             state_q, state_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [IDX_W-1:0]     ptr_q;
  logic [NUM_M-1:0]     gnt_q;
  logic [NUM_M-1:0]     rvalid_q;
  logic                 busy_q;
  logic                 wr_q;
  logic [ADDR_W-1:0]    a_q;
  logic [DATA_W-1:0]    din_q;

  logic                 lock_held_c;
  logic [NUM_M-1:0]     elig_c;
  logic [NUM_M-1:0]     mask_c;
  logic [NUM_M-1:0]     pick_c;
  logic                 win_vld_c;
  logic [IDX_W-1:0]     win_idx_c;
  logic [ADDR_W-1:0]    sel_a_c;
  logic [DATA_W-1:0]    sel_d_c;
  logic                 sel_rnw_c;
  logic [IDX_W-1:0]     ptr_nxt_c;

  // Owner restricts eligibility only while its m_lock is still high at this edge.
  assign lock_held_c = (state_q == ST_LOCKED) && bus.m_lock[owner_q];

  always_comb begin
    elig_c = '0;
    if (bus.ovr) begin
      elig_c[OVR_IDX] = bus.m_req[OVR_IDX];
    end else if (lock_held_c) begin
      elig_c[owner_q] = bus.m_req[owner_q];
    end else begin
      elig_c = bus.m_req;
    end
  end

  // Round-robin: prefer eligible masters at or above ptr, else wrap to the lowest.
  always_comb begin
    mask_c    = '0;
    win_vld_c = 1'b0;
    win_idx_c = '0;
    for (int i = 0; i < NUM_M; i++) begin
      mask_c[i] = (IDX_W'(i) >= ptr_q);
    end
    pick_c = (|(elig_c & mask_c)) ? (elig_c & mask_c) : elig_c;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (pick_c[i]) begin
        win_vld_c = 1'b1;
        win_idx_c = IDX_W'(i);
      end
    end
  end

  always_comb begin
    sel_a_c   = '0;
    sel_d_c   = '0;
    sel_rnw_c = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      if (win_idx_c == IDX_W'(i)) begin
        sel_a_c   = bus.m_a[i*ADDR_W +: ADDR_W];
        sel_d_c   = bus.m_wdata[i*DATA_W +: DATA_W];
        sel_rnw_c = bus.m_r_nw[i];
      end
    end
  end

  assign ptr_nxt_c = (win_idx_c == IDX_W'(NUM_M - 1)) ? '0 : win_idx_c + IDX_W'(1);

  // Lock ownership FSM: state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_OPEN;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
    end
  end

  // Lock ownership FSM: next state.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    unique case (state_q)
      ST_OPEN: begin
        if (win_vld_c && bus.m_lock[win_idx_c]) begin
          state_d = ST_LOCKED;
          owner_d = win_idx_c;
        end
      end
      ST_LOCKED: begin
        if (win_vld_c && bus.m_lock[win_idx_c]) begin
          owner_d = win_idx_c;
        end else if (!bus.m_lock[owner_q]) begin
          state_d = ST_OPEN;
        end
      end
      default: state_d = ST_OPEN;
    endcase
  end

  // Issue stage and read-return pipeline; a reset drops any pending read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q    <= '0;
      gnt_q    <= '0;
      rvalid_q <= '0;
      busy_q   <= 1'b0;
      wr_q     <= 1'b0;
      a_q      <= '0;
      din_q    <= '0;
    end else begin
      rvalid_q <= busy_q ? gnt_q : '0;
      if (win_vld_c) begin
        gnt_q  <= NUM_M'(1) << win_idx_c;
        a_q    <= sel_a_c;
        din_q  <= sel_d_c;
        wr_q   <= ~sel_rnw_c;
        busy_q <= sel_rnw_c;
        ptr_q  <= ptr_nxt_c;
      end else begin
        gnt_q  <= '0;
        wr_q   <= 1'b0;
        busy_q <= 1'b0;
      end
    end
  end

  assign bus.m_gnt    = gnt_q;
  assign bus.m_rvalid = rvalid_q;
  assign bus.m_rdata  = bus.mc_dout;
  assign bus.busy     = busy_q;
  assign bus.mc_a     = a_q;
  assign bus.mc_wr    = wr_q;
  assign bus.mc_din   = din_q;

endmodule
